// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64I opcodes, mux encodings, control state and bundle types
package rv_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_ALU      = 2'd1;
  localparam logic [1:0] PC_ALU_JALR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       alu_word;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode to control bundle decoder
module mc_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  // Map each supported major opcode onto its operand, immediate and class controls
  always_comb begin
    ctrl       = '0;
    ctrl.legal = 1'b1;
    case (opcode)
      OPC_LUI: begin
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      OPC_AUIPC: begin
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      OPC_OP: begin
        ctrl.alu_src_b = SRC_B_RS2;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src_b = SRC_B_IMM;
      end
      OPC_OP_32: begin
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_word  = 1'b1;
      end
      OPC_OP_IMM_32: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_word  = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_sel   = IMM_J;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.is_jal    = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.is_jalr   = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_BRANCH: begin
        ctrl.imm_sel   = IMM_B;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.is_load   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        ctrl.imm_sel   = IMM_S;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.is_store  = 1'b1;
      end
      default: begin
        ctrl.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV64I multi-cycle control FSM with memory watchdog and instret
module multicycle_control
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_is_fetch,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [2:0]           imm_sel,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic                 alu_word,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 illegal_inst,
  output logic                 bus_error,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      retire_target;
  ctrl_t       ctrl;
  logic        started;
  logic [15:0] wd_cnt;
  logic        unused_inst_bits;

  // Only the major opcode steers control; the rest of IR belongs to the datapath
  assign unused_inst_bits = ^inst[31:7];

  mc_decode u_decode (
    .opcode (inst[6:0]),
    .ctrl   (ctrl)
  );

  // A retiring instruction lands in HALT instead of FETCH when debug asks for it
  assign retire_target = halt_req ? ST_HALT : ST_FETCH;
  assign halted        = (state == ST_HALT);

  // Per-state datapath controls; memory handshakes complete in the mem_ready cycle
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    imm_sel      = IMM_I;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_word     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    case (state)
      ST_FETCH: begin
        // The first cycle out of reset only samples halt_req, so no request yet
        if (started) begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          ir_write     = mem_ready;
        end
      end
      ST_EXEC: begin
        imm_sel   = ctrl.imm_sel;
        alu_src_a = ctrl.alu_src_a;
        alu_src_b = ctrl.alu_src_b;
        alu_word  = ctrl.alu_word;
        if (ctrl.is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_ALU : PC_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = ctrl.is_store;
        pc_write = mem_ready && ctrl.is_store;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = ctrl.wb_sel;
        pc_write  = 1'b1;
        if (ctrl.is_jalr)     pc_src = PC_ALU_JALR;
        else if (ctrl.is_jal) pc_src = PC_ALU;
        else                  pc_src = PC_PLUS4;
      end
      default: begin
      end
    endcase
  end

  // State sequencing, sticky error flags, memory watchdog and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FETCH;
      started      <= 1'b0;
      wd_cnt       <= '0;
      illegal_inst <= 1'b0;
      bus_error    <= 1'b0;
      instret      <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!started) begin
            started <= 1'b1;
            if (halt_req) state <= ST_HALT;
          end else if (mem_ready) begin
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ctrl.legal) begin
            state <= ST_EXEC;
          end else begin
            illegal_inst <= 1'b1;
            state        <= ST_TRAP;
          end
        end
        ST_EXEC: begin
          if (ctrl.is_branch)                     state <= retire_target;
          else if (ctrl.is_load || ctrl.is_store) state <= ST_MEM;
          else                                    state <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready) state <= ctrl.is_store ? retire_target : ST_WB;
        end
        ST_WB: begin
          state <= retire_target;
        end
        ST_HALT: begin
          if (!halt_req) state <= ST_FETCH;
        end
        default: begin
        end
      endcase

      // Stalled request cycles are counted; expiry overrides the state update above
      if (mem_req && !mem_ready) begin
        if (wd_cnt == WD_LAST) begin
          bus_error <= 1'b1;
          state     <= ST_TRAP;
          wd_cnt    <= '0;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
      end else begin
        wd_cnt <= '0;
      end

      if (pc_write) instret <= instret + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int CW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   inst = '0;
  logic          mem_ready = 1'b0;
  logic          halt_req = 1'b0;
  logic          branch_taken = 1'b0;
  logic          mem_req, mem_we, mem_is_fetch, ir_write, pc_write;
  logic [1:0]    pc_src, alu_src_a, wb_sel;
  logic [2:0]    imm_sel;
  logic          alu_src_b, alu_word, reg_write;
  logic          illegal_inst, bus_error, halted;
  logic [CW-1:0] instret;

  typedef struct {
    int         cyc;
    logic [1:0] pc_src;
    logic       rw;
    logic [1:0] wb;
    logic [2:0] imm;
    logic [1:0] asa;
    logic       word;
    logic       we;
    int         memcyc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_ret = 0;
  int mem_wait = 0;
  bit hold_off = 0;
  bit halt_arm = 0;
  longint exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .mem_ready    (mem_ready),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_word     (alu_word),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal_inst (illegal_inst),
    .bus_error    (bus_error),
    .halted       (halted),
    .instret      (instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: fetches answer at once, data accesses after mem_wait stall cycles
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) wcnt = 0;
      if (halt_arm && mem_req && !mem_is_fetch) halt_req = 1'b1;
      if (mem_req && !hold_off) begin
        if (wcnt >= (mem_is_fetch ? 0 : mem_wait)) begin
          mem_ready = 1'b1;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: builds an observed record per instruction and compares it at retire
  initial begin
    bit   in_inst = 0;
    exp_t o;
    exp_t e;
    string t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_inst = 0;
      end else begin
        if (!in_inst && mem_req && mem_is_fetch) begin
          in_inst = 1;
          o = '{0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0};
        end
        if (in_inst) begin
          o.cyc++;
          if (o.cyc == 3) begin
            o.imm  = imm_sel;
            o.asa  = alu_src_a;
            o.word = alu_word;
          end
          if (reg_write) begin
            o.rw = 1'b1;
            o.wb = wb_sel;
          end
          if (mem_req && !mem_is_fetch) o.memcyc++;
          if (mem_req && mem_we) o.we = 1'b1;
          if (pc_write) begin
            o.pc_src = pc_src;
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              t = tag_q.pop_front();
              check({t, "_cycles"}, o.cyc, e.cyc);
              check({t, "_pc_src"}, o.pc_src, e.pc_src);
              check({t, "_reg_write"}, o.rw, e.rw);
              check({t, "_wb_sel"}, o.wb, e.wb);
              check({t, "_imm_sel"}, o.imm, e.imm);
              check({t, "_alu_src_a"}, o.asa, e.asa);
              check({t, "_alu_word"}, o.word, e.word);
              check({t, "_mem_we"}, o.we, e.we);
              check({t, "_mem_cycles"}, o.memcyc, e.memcyc);
            end
            in_inst = 0;
            n_ret++;
          end
        end
      end
    end
  end

  task automatic do_inst(input string tag, input logic [31:0] instr, input int mw,
                         input logic tk, input exp_t e);
    int  r0;
    bit  done;
    r0 = n_ret;
    done = 0;
    inst = instr;
    mem_wait = mw;
    branch_taken = tk;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (n_ret != r0) begin
        done = 1;
        break;
      end
    end
    check({tag, "_retired"}, done, 1);
    @(posedge clk);
    #1;
    exp_instret++;
    check({tag, "_instret"}, instret, exp_instret);
  endtask

  initial begin
    int cnt;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_illegal", illegal_inst, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_halted", halted, 0);
    check("rst_instret", instret, 0);
    rst_n = 1'b1;

    do_inst("addi",  32'h00500093, 0, 1'b0, '{4, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 0});
    do_inst("lw",    32'h0000A103, 3, 1'b0, '{8, 2'd0, 1'b1, 2'd1, 3'd0, 2'd0, 1'b0, 1'b0, 4});
    do_inst("beq_t", 32'h00000463, 0, 1'b1, '{3, 2'd1, 1'b0, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 0});
    do_inst("beq_n", 32'h00000463, 0, 1'b0, '{3, 2'd0, 1'b0, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0, 0});
    do_inst("sw",    32'h0020A223, 0, 1'b0, '{4, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 1});
    do_inst("jal",   32'h010000EF, 0, 1'b0, '{4, 2'd1, 1'b1, 2'd2, 3'd4, 2'd1, 1'b0, 1'b0, 0});
    do_inst("jalr",  32'h00008067, 0, 1'b0, '{4, 2'd2, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0, 1'b0, 0});
    do_inst("lui",   32'h123450B7, 0, 1'b0, '{4, 2'd0, 1'b1, 2'd0, 3'd3, 2'd2, 1'b0, 1'b0, 0});
    do_inst("addiw", 32'h0050809B, 0, 1'b0, '{4, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0, 0});

    halt_arm = 1;
    do_inst("sw_halt", 32'h0020A223, 1, 1'b0, '{5, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 1'b1, 2});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_no_req", mem_req, 0);
    end
    halt_arm = 0;
    inst = 32'h0000007F;
    halt_req = 1'b0;
    @(negedge clk);
    check("unhalt_halted", halted, 0);
    check("unhalt_fetch", mem_req && mem_is_fetch, 1);

    repeat (3) @(negedge clk);
    check("illegal_set", illegal_inst, 1);
    check("illegal_instret", instret, exp_instret);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("trap_no_req", cnt, 0);

    rst_n = 1'b0;
    #1;
    check("rst2_illegal", illegal_inst, 0);
    check("rst2_instret", instret, 0);
    check("rst2_mem_req", mem_req, 0);
    hold_off = 1;
    @(negedge clk);
    rst_n = 1'b1;

    cnt = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_error) begin
        seen = 1;
        break;
      end
      if (mem_req) cnt++;
    end
    check("bus_err_set", seen, 1);
    check("bus_err_wait_cycles", cnt, 4);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("bus_err_no_req", cnt, 0);
    check("bus_err_sticky", bus_error, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
